// File: rtl/fft_fixed_pkg.sv
// Shared fixed-point formats (Q8.8 data, Q2.6 twiddle) and the divider FSM encoding,
// used by the multiplier, butterfly and sequential divider.
package fft_fixed_pkg;

  localparam int DATA_W    = 16;
  localparam int DATA_FRAC = 8;
  localparam int TW_W      = 8;
  localparam int TW_FRAC   = 6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    FIX    = 2'd2,
    DONE   = 2'd3
  } div_state_e;

endpackage

// File: rtl/seq_signed_divider_div_sat_round.sv
// div_sat_round: restores the quotient sign and saturates to the signed DATA_W range.
// Optional macro DIV_ROUND_EN adds round-half-away-from-zero on the magnitude.
module div_sat_round #(
  parameter int DATA_W = 16,
  parameter int QW     = 22,
  parameter int RW     = 9,
  parameter int DW     = 8
) (
  input  logic [QW-1:0]     mag_i,
  input  logic [RW-1:0]     rem_i,
  input  logic [DW-1:0]     dmag_i,
  input  logic              neg_i,
  input  logic              din_neg_i,
  input  logic              zero_i,
  output logic [DATA_W-1:0] res_o
);

  localparam logic [DATA_W-1:0] MAX_POS = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] MAX_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  logic [QW:0] mag_r;

`ifndef DIV_ROUND_EN
  logic unused_rem;
  assign unused_rem = ^{rem_i, dmag_i};
`endif

  // NOTE: every output of an always_comb gets a default first so no path can infer a latch.
  always_comb begin
    mag_r = {1'b0, mag_i};
`ifdef DIV_ROUND_EN
    if ({1'b0, rem_i, 1'b0} >= (RW+2)'(dmag_i))
      mag_r = mag_r + (QW+1)'(1);
`endif
    res_o = mag_r[DATA_W-1:0];
    if (zero_i) begin
      res_o = din_neg_i ? MAX_NEG : MAX_POS;
    end else if (neg_i) begin
      // Magnitude 2^(DATA_W-1) is still representable on the negative side.
      if (mag_r > (QW+1)'(MAX_NEG)) res_o = MAX_NEG;
      else                          res_o = -mag_r[DATA_W-1:0];
    end else if (mag_r > (QW+1)'(MAX_POS)) begin
      res_o = MAX_POS;
    end
  end

endmodule

// File: rtl/seq_signed_divider.sv
// Sequential signed divider, Q8.8 / Q2.6 -> Q8.8: inverse of the data x twiddle multiplier.
// Restoring division on magnitudes, one quotient bit per cycle; optional macro DIV_ROUND_EN.
module seq_signed_divider #(
  parameter int DATA_W  = fft_fixed_pkg::DATA_W,
  parameter int TW_W    = fft_fixed_pkg::TW_W,
  parameter int TW_FRAC = fft_fixed_pkg::TW_FRAC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] din,
  input  logic [TW_W-1:0]   W,
  output logic [DATA_W-1:0] dout,
  output logic              busy,
  output logic              done,
  output logic              div_by_zero
);

  import fft_fixed_pkg::*;

  localparam int QW = DATA_W + TW_FRAC;
  localparam int RW = TW_W + 1;
  localparam int CW = $clog2(QW);

  div_state_e        state_q;
  logic [CW-1:0]     cnt_q;
  logic [QW-1:0]     quo_q;
  logic [RW-1:0]     rem_q;
  logic [TW_W-1:0]   dmag_q;
  logic              neg_q, din_neg_q, zero_q;
  logic [DATA_W-1:0] res_q, dout_q;
  logic              busy_q, done_q, dbz_q;

  logic [DATA_W-1:0] din_mag;
  logic [TW_W-1:0]   w_mag;
  logic [RW-1:0]     rem_shift, rem_next;
  logic              q_bit;
  logic [DATA_W-1:0] fixed_res;

  // Two's-complement negate of the most negative value yields its true unsigned magnitude.
  assign din_mag = din[DATA_W-1] ? -din : din;
  assign w_mag   = W[TW_W-1]     ? -W   : W;

  always_comb begin
    rem_shift = {rem_q[RW-2:0], quo_q[QW-1]};
    q_bit     = (rem_shift >= {1'b0, dmag_q});
    rem_next  = q_bit ? rem_shift - {1'b0, dmag_q} : rem_shift;
  end

  div_sat_round #(
    .DATA_W (DATA_W),
    .QW     (QW),
    .RW     (RW),
    .DW     (TW_W)
  ) u_fix (
    .mag_i     (quo_q),
    .rem_i     (rem_q),
    .dmag_i    (dmag_q),
    .neg_i     (neg_q),
    .din_neg_i (din_neg_q),
    .zero_i    (zero_q),
    .res_o     (fixed_res)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: the datapath registers are not reset; they are always loaded on accept before use.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dout_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && !done_q) begin
            quo_q     <= {din_mag, {TW_FRAC{1'b0}}};
            rem_q     <= '0;
            dmag_q    <= w_mag;
            neg_q     <= din[DATA_W-1] ^ W[TW_W-1];
            din_neg_q <= din[DATA_W-1];
            zero_q    <= (W == '0);
            busy_q    <= 1'b1;
            dbz_q     <= 1'b0;
            // The zero-divisor path idles one cycle in FIX to give it a fixed 3-edge response.
            if (W == '0) begin
              state_q <= FIX;
              cnt_q   <= CW'(1);
            end else begin
              state_q <= DIVIDE;
              cnt_q   <= CW'(QW - 1);
            end
          end
        end
        DIVIDE: begin
          quo_q <= {quo_q[QW-2:0], q_bit};
          rem_q <= rem_next;
          if (cnt_q == '0) state_q <= FIX;
          else             cnt_q   <= cnt_q - CW'(1);
        end
        FIX: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
          end else begin
            res_q   <= fixed_res;
            state_q <= DONE;
          end
        end
        DONE: begin
          dout_q  <= res_q;
          dbz_q   <= zero_q;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dout        = dout_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule
